// File: rtl/mesh_pe_cx_pkg.sv
// Shared types and schedule helpers for the shearsort mesh node.
package mesh_pe_cx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SORT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    DIR_L = 2'd0,
    DIR_R = 2'd1,
    DIR_U = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  localparam logic PHASE_ROW = 1'b0;
  localparam logic PHASE_COL = 1'b1;

  // Snake shearsort needs 2*log2(side)+1 alternating phases, ending on a row phase.
  function automatic int sched_phases(input int sqrt_n);
    return 2 * $clog2(sqrt_n) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mesh_pe_cx_if.sv
// Node-side bus of one mesh PE: load/start controls, neighbour words, status.
// MESH_PE_DBG_SEL_EN adds the debug neighbour-select controls.
interface mesh_pe_cx_if #(
  parameter int W = 6
);
  logic         i_load;
  logic [W-1:0] i_load_word;
  logic         i_start;
  logic [W-1:0] i_PE_l;
  logic [W-1:0] i_PE_r;
  logic [W-1:0] i_PE_u;
  logic [W-1:0] i_PE_d;
  logic [W-1:0] o_PE;
  logic         o_busy;
  logic         o_done;
`ifdef MESH_PE_DBG_SEL_EN
  logic         i_sel_en;
  logic [1:0]   i_sel_dir;

  modport master (
    output i_load, i_load_word, i_start, i_PE_l, i_PE_r, i_PE_u, i_PE_d,
           i_sel_en, i_sel_dir,
    input  o_PE, o_busy, o_done
  );

  modport slave (
    input  i_load, i_load_word, i_start, i_PE_l, i_PE_r, i_PE_u, i_PE_d,
           i_sel_en, i_sel_dir,
    output o_PE, o_busy, o_done
  );
`else
  modport master (
    output i_load, i_load_word, i_start, i_PE_l, i_PE_r, i_PE_u, i_PE_d,
    input  o_PE, o_busy, o_done
  );

  modport slave (
    input  i_load, i_load_word, i_start, i_PE_l, i_PE_r, i_PE_u, i_PE_d,
    output o_PE, o_busy, o_done
  );
`endif
endinterface

// File: rtl/mesh_pe_cx_seq.sv
// Phase/step sequencer for the shearsort schedule.
//   state   | meaning
//   ST_IDLE | waiting for start; word may be loaded
//   ST_SORT | one compare-exchange per edge at (phase, step)
//   ST_DONE | one-cycle completion pulse, then back to idle
module mesh_pe_cx_seq
  import mesh_pe_cx_pkg::*;
#(
  parameter int PHASES = 3,
  parameter int STEPS  = 2,
  parameter int PW     = 2,
  parameter int SW     = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic [PW-1:0] phase,
  output logic [SW-1:0] step,
  output logic          busy,
  output logic          done
);

  state_t        state, state_nxt;
  logic [PW-1:0] phase_nxt;
  logic [SW-1:0] step_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      phase <= '0;
      step  <= '0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    step_nxt  = step;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_SORT;
          phase_nxt = '0;
          step_nxt  = '0;
        end
      end
      ST_SORT: begin
        if (step == SW'(STEPS - 1)) begin
          step_nxt = '0;
          if (phase == PW'(PHASES - 1)) begin
            phase_nxt = '0;
            state_nxt = ST_DONE;
          end else begin
            phase_nxt = phase + PW'(1);
          end
        end else begin
          step_nxt = step + SW'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SORT);
  assign done = (state == ST_DONE);

endmodule

// File: rtl/mesh_pe_cx.sv
// One shearsort node of a SQRT_N x SQRT_N mesh: partner select, compare-exchange, word register.
// Optional debug neighbour capture is enabled with MESH_PE_DBG_SEL_EN.
module mesh_pe_cx
  import mesh_pe_cx_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 3,
  parameter int SQRT_N     = 2,
  parameter int ROW        = 0,
  parameter int COL        = 0,
  parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1
) (
  input logic         clk,
  input logic         rst,
  mesh_pe_cx_if.slave bus
);

  localparam int W      = ADDR_WIDTH + DATA_WIDTH;
  localparam int PHASES = sched_phases(SQRT_N);
  localparam int STEPS  = SQRT_N;
  localparam int PW     = cnt_width(PHASES);
  localparam int SW     = cnt_width(STEPS);

  localparam bit HAS_L   = (COL > 0);
  localparam bit HAS_R   = (COL < SQRT_N - 1);
  localparam bit HAS_U   = (ROW > 0);
  localparam bit HAS_D   = (ROW < SQRT_N - 1);
  localparam bit ROW_ODD = ((ROW % 2) == 1);
  localparam bit COL_ODD = ((COL % 2) == 1);

  logic [PW-1:0] phase;
  logic [SW-1:0] step;
  logic          busy;
  logic          done;
  logic [W-1:0]  word, word_nxt;
  logic [W-1:0]  partner;
  logic [W-1:0]  exch_word;
  logic          has_partner;
  logic          keep_min;
  logic          unused_cnt;

  mesh_pe_cx_seq #(
    .PHASES (PHASES),
    .STEPS  (STEPS),
    .PW     (PW),
    .SW     (SW)
  ) u_seq (
    .clk   (clk),
    .rst   (rst),
    .start (bus.i_start),
    .phase (phase),
    .step  (step),
    .busy  (busy),
    .done  (done)
  );

  // Only the parities of phase and step matter to the pairing.
  assign unused_cnt = ^{phase, step};

  // (pos + step) is even exactly when step and pos have the same parity.
  always_comb begin
    has_partner = 1'b0;
    keep_min    = 1'b0;
    partner     = word;
    if (phase[0] == PHASE_ROW) begin
      if (step[0] == COL_ODD) begin
        if (HAS_R) begin
          has_partner = 1'b1;
          partner     = bus.i_PE_r;
          keep_min    = !ROW_ODD;
        end
      end else if (HAS_L) begin
        has_partner = 1'b1;
        partner     = bus.i_PE_l;
        keep_min    = ROW_ODD;
      end
    end else begin
      if (step[0] == ROW_ODD) begin
        if (HAS_D) begin
          has_partner = 1'b1;
          partner     = bus.i_PE_d;
          keep_min    = 1'b1;
        end
      end else if (HAS_U) begin
        has_partner = 1'b1;
        partner     = bus.i_PE_u;
        keep_min    = 1'b0;
      end
    end
  end

  always_comb begin
    exch_word = word;
    if (has_partner) begin
      if (keep_min) exch_word = (partner < word) ? partner : word;
      else          exch_word = (partner > word) ? partner : word;
    end
  end

`ifdef MESH_PE_DBG_SEL_EN
  logic [W-1:0] sel_word;

  always_comb begin
    sel_word = bus.i_PE_l;
    case (dir_t'(bus.i_sel_dir))
      DIR_L:   sel_word = bus.i_PE_l;
      DIR_R:   sel_word = bus.i_PE_r;
      DIR_U:   sel_word = bus.i_PE_u;
      DIR_D:   sel_word = bus.i_PE_d;
      default: sel_word = bus.i_PE_l;
    endcase
  end
`endif

  always_comb begin
    word_nxt = word;
    if (busy) begin
      word_nxt = exch_word;
    end else if (!done) begin
      if (bus.i_start) begin
        word_nxt = word;
`ifdef MESH_PE_DBG_SEL_EN
      end else if (bus.i_sel_en) begin
        word_nxt = sel_word;
`endif
      end else if (bus.i_load) begin
        word_nxt = bus.i_load_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) word <= MAX_INT;
    else      word <= word_nxt;
  end

  assign bus.o_PE   = word;
  assign bus.o_busy = busy;
  assign bus.o_done = done;

endmodule

// File: tb/tb_mesh_pe_cx.sv
// Directed bench: a 2x2 mesh plus a 1x1 node, checked against hand-computed words.
module tb_mesh_pe_cx;

  localparam int W = 6;
  localparam logic [W-1:0] MAXW = '1;

  logic clk;
  logic rst;
  logic start_m;
  logic load_m;
  logic [W-1:0] lw [4];
  int n_checks = 0;
  int n_errors = 0;

  mesh_pe_cx_if #(.W(W)) if00 (), if01 (), if10 (), if11 (), ifs ();

  mesh_pe_cx #(.SQRT_N(2), .ROW(0), .COL(0)) u00 (.clk(clk), .rst(rst), .bus(if00));
  mesh_pe_cx #(.SQRT_N(2), .ROW(0), .COL(1)) u01 (.clk(clk), .rst(rst), .bus(if01));
  mesh_pe_cx #(.SQRT_N(2), .ROW(1), .COL(0)) u10 (.clk(clk), .rst(rst), .bus(if10));
  mesh_pe_cx #(.SQRT_N(2), .ROW(1), .COL(1)) u11 (.clk(clk), .rst(rst), .bus(if11));
  mesh_pe_cx #(.SQRT_N(1), .ROW(0), .COL(0)) us  (.clk(clk), .rst(rst), .bus(ifs));

  assign if00.i_start = start_m;  assign if00.i_load = load_m;  assign if00.i_load_word = lw[0];
  assign if01.i_start = start_m;  assign if01.i_load = load_m;  assign if01.i_load_word = lw[1];
  assign if10.i_start = start_m;  assign if10.i_load = load_m;  assign if10.i_load_word = lw[2];
  assign if11.i_start = start_m;  assign if11.i_load = load_m;  assign if11.i_load_word = lw[3];

  // Interior links
  assign if00.i_PE_r = if01.o_PE;  assign if00.i_PE_d = if10.o_PE;
  assign if01.i_PE_l = if00.o_PE;  assign if01.i_PE_d = if11.o_PE;
  assign if10.i_PE_r = if11.o_PE;  assign if10.i_PE_u = if00.o_PE;
  assign if11.i_PE_l = if10.o_PE;  assign if11.i_PE_u = if01.o_PE;
  // Edge inputs carry values that would corrupt the word if they were not ignored
  assign if00.i_PE_l = MAXW;  assign if00.i_PE_u = MAXW;
  assign if01.i_PE_r = '0;    assign if01.i_PE_u = MAXW;
  assign if10.i_PE_l = MAXW;  assign if10.i_PE_d = '0;
  assign if11.i_PE_r = '0;    assign if11.i_PE_d = '0;

`ifdef MESH_PE_DBG_SEL_EN
  assign if00.i_sel_en = 1'b0;  assign if00.i_sel_dir = 2'd0;
  assign if01.i_sel_en = 1'b0;  assign if01.i_sel_dir = 2'd0;
  assign if10.i_sel_en = 1'b0;  assign if10.i_sel_dir = 2'd0;
  assign if11.i_sel_en = 1'b0;  assign if11.i_sel_dir = 2'd0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mesh_words();
    return 32'({if00.o_PE, if01.o_PE, if10.o_PE, if11.o_PE});
  endfunction

  function automatic logic [31:0] mesh_busy();
    return 32'({if00.o_busy, if01.o_busy, if10.o_busy, if11.o_busy});
  endfunction

  function automatic logic [31:0] mesh_done();
    return 32'({if00.o_done, if01.o_done, if10.o_done, if11.o_done});
  endfunction

  task automatic load_3210();
    lw[0] = 6'd3; lw[1] = 6'd2; lw[2] = 6'd1; lw[3] = 6'd0;
    load_m = 1'b1;
    tick();
    load_m = 1'b0;
  endtask

  // Load 3,2,1,0 and sort; optionally pulse start/load while sorting.
  task automatic run_sort(input bit inject, input string tag);
    int cnt;
    load_3210();
    check({tag, "_load"}, mesh_words(), 32'({6'd3, 6'd2, 6'd1, 6'd0}));
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    check({tag, "_busy"}, mesh_busy(), 32'hF);
    lw[0] = 6'd7; lw[1] = 6'd7; lw[2] = 6'd7; lw[3] = 6'd7;
    cnt = 0;
    while (!if00.o_done && cnt < 20) begin
      start_m = inject && (cnt == 2 || cnt == 3);
      load_m  = inject && (cnt == 2 || cnt == 3);
      tick();
      cnt++;
    end
    start_m = 1'b0;
    load_m  = 1'b0;
    check({tag, "_cycles"}, 32'(cnt), 32'd6);
    check({tag, "_done"}, mesh_done(), 32'hF);
    check({tag, "_busy_end"}, mesh_busy(), 32'h0);
    check({tag, "_words"}, mesh_words(), 32'({6'd0, 6'd1, 6'd3, 6'd2}));
    tick();
    check({tag, "_done_pulse"}, mesh_done(), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    start_m = 1'b0;
    load_m = 1'b0;
    lw = '{default: '0};
    ifs.i_load = 1'b0;
    ifs.i_start = 1'b0;
    ifs.i_load_word = '0;
    ifs.i_PE_l = MAXW;
    ifs.i_PE_u = MAXW;
    ifs.i_PE_r = '0;
    ifs.i_PE_d = '0;
`ifdef MESH_PE_DBG_SEL_EN
    ifs.i_sel_en = 1'b0;
    ifs.i_sel_dir = 2'd0;
`endif

    // Reset state and first load
    #2 rst = 1'b0;
    tick();
    tick();
    check("rst_mesh_words", mesh_words(), 32'hFF_FFFF);
    check("rst_single_word", 32'(ifs.o_PE), 32'(MAXW));
    check("rst_busy", 32'({mesh_busy()[3:0], ifs.o_busy}), 32'h0);
    check("rst_done", 32'({mesh_done()[3:0], ifs.o_done}), 32'h0);
    rst = 1'b1;
    ifs.i_load_word = 6'b010000;
    ifs.i_load = 1'b1;
    tick();
    ifs.i_load = 1'b0;
    check("load_single", 32'(ifs.o_PE), 32'(6'b010000));

    // Degenerate 1x1 mesh
    ifs.i_load_word = 6'b000101;
    ifs.i_load = 1'b1;
    tick();
    ifs.i_load = 1'b0;
    ifs.i_start = 1'b1;
    tick();
    ifs.i_start = 1'b0;
    check("n1_busy", 32'({ifs.o_busy, ifs.o_done}), 32'b10);
    tick();
    check("n1_done", 32'({ifs.o_busy, ifs.o_done}), 32'b01);
    check("n1_word", 32'(ifs.o_PE), 32'(6'b000101));
    tick();
    check("n1_idle", 32'({ifs.o_busy, ifs.o_done}), 32'b00);

    // Full 2x2 sort
    run_sort(1'b0, "sort");

    // Asynchronous reset in the middle of a sort
    load_3210();
    start_m = 1'b1;
    tick();
    start_m = 1'b0;
    tick();
    tick();
    tick();
    #3 rst = 1'b0;
    #1;
    check("midrst_words", mesh_words(), 32'hFF_FFFF);
    check("midrst_busy", mesh_busy(), 32'h0);
    tick();
    rst = 1'b1;
    run_sort(1'b0, "after_rst");

    // Start/load during the sort must be ignored
    run_sort(1'b1, "inject");

`ifdef MESH_PE_DBG_SEL_EN
    ifs.i_PE_r = 6'b010000;
    ifs.i_sel_dir = 2'd1;
    ifs.i_sel_en = 1'b1;
    ifs.i_load_word = 6'b000111;
    ifs.i_load = 1'b1;
    tick();
    ifs.i_load = 1'b0;
    check("dbg_sel_r", 32'(ifs.o_PE), 32'(6'b010000));
    ifs.i_sel_dir = 2'd2;
    tick();
    ifs.i_sel_en = 1'b0;
    check("dbg_sel_u", 32'(ifs.o_PE), 32'(MAXW));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
